// File: rtl/edge_event_detector.sv
// Multi-channel edge detector: optional synchroniser, glitch filter,
// rise/fall pulse selection, sticky flags and a saturating event counter.
module edge_event_detector #(
    parameter int WIDTH         = 8,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 0,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] din,
    input  logic [WIDTH-1:0] rise_en,
    input  logic [WIDTH-1:0] fall_en,
    input  logic [WIDTH-1:0] clr,
    input  logic             count_clr,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] sticky,
    output logic             any_event,
    output logic [CNT_W-1:0] count
);

    localparam int FW = (FILTER_CYCLES > 0) ? $clog2(FILTER_CYCLES + 1) : 1;
    localparam int PW = $clog2(WIDTH + 1);
    localparam logic [FW-1:0] FMAX = FW'(FILTER_CYCLES);
    localparam logic [CNT_W:0] CMAX = {1'b0, {CNT_W{1'b1}}};

    logic [WIDTH-1:0] s;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign s = din;
        end else begin : g_sync
            logic [WIDTH-1:0] sync_q [SYNC_STAGES];

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    for (int k = 0; k < SYNC_STAGES; k++) begin
                        sync_q[k] <= '0;
                    end
                end else begin
                    sync_q[0] <= din;
                    for (int k = 1; k < SYNC_STAGES; k++) begin
                        sync_q[k] <= sync_q[k-1];
                    end
                end
            end

            assign s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    logic [FW-1:0]    fcnt_q [WIDTH];
    logic [FW-1:0]    fcnt_d [WIDTH];
    logic [WIDTH-1:0] lvl_q, lvl_d;
    logic [WIDTH-1:0] accept;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [WIDTH-1:0] sticky_q, sticky_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PW-1:0]    pop;
    logic [CNT_W:0]   sum;

    // A new level is accepted once it has held FILTER_CYCLES+1 samples.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            accept[i] = (s[i] != lvl_q[i]) && (fcnt_q[i] == FMAX);
            lvl_d[i]  = accept[i] ? s[i] : lvl_q[i];
            if ((s[i] == lvl_q[i]) || accept[i]) begin
                fcnt_d[i] = '0;
            end else begin
                fcnt_d[i] = fcnt_q[i] + FW'(1);
            end
        end
    end

    assign dout_d   = accept & ((s & rise_en) | (~s & fall_en));
    assign sticky_d = dout_d | (sticky_q & ~clr);

    always_comb begin
        pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop = pop + PW'(dout_q[i]);
        end
    end

    // Clearing still counts this cycle's pulses so none are lost.
    always_comb begin
        sum = {1'b0, count_q} + (CNT_W+1)'(pop);
        if (count_clr) begin
            count_d = CNT_W'(pop);
        end else if (sum > CMAX) begin
            count_d = CMAX[CNT_W-1:0];
        end else begin
            count_d = sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lvl_q    <= '0;
            dout_q   <= '0;
            sticky_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                fcnt_q[i] <= '0;
            end
        end else begin
            lvl_q    <= lvl_d;
            dout_q   <= dout_d;
            sticky_q <= sticky_d;
            count_q  <= count_d;
            for (int i = 0; i < WIDTH; i++) begin
                fcnt_q[i] <= fcnt_d[i];
            end
        end
    end

    assign dout      = dout_q;
    assign sticky    = sticky_q;
    assign any_event = |dout_q;
    assign count     = count_q;

endmodule

// File: tb/tb_edge_event_detector.sv
// Scoreboard bench for edge_event_detector: two instances, one unfiltered
// with a 4-bit counter, one with a 2-flop synchroniser and 3-cycle filter.
module tb_edge_event_detector;

    localparam int DOUT = 0;
    localparam int STK  = 1;
    localparam int CNT  = 2;
    localparam int ANY  = 3;

    logic       clk;
    logic       resetn;
    logic [7:0] a_din, a_rise, a_fall, a_clr;
    logic       a_cclr;
    logic [7:0] a_dout, a_sticky;
    logic       a_any;
    logic [3:0] a_count;
    logic [7:0] b_din, b_rise, b_fall, b_clr;
    logic       b_cclr;
    logic [7:0] b_dout, b_sticky;
    logic       b_any;
    logic [7:0] b_count;

    int cyc = 0;
    int checks = 0;
    int failures = 0;
    event async_ev;

    typedef struct {
        int         cyc;
        bit         ph;
        bit         dut;
        int         fld;
        logic [7:0] val;
        string      name;
    } exp_t;

    exp_t sb[$];

    edge_event_detector #(
        .WIDTH(8), .SYNC_STAGES(0), .FILTER_CYCLES(0), .CNT_W(4)
    ) u_a (
        .clk(clk), .resetn(resetn), .din(a_din),
        .rise_en(a_rise), .fall_en(a_fall), .clr(a_clr),
        .count_clr(a_cclr), .dout(a_dout), .sticky(a_sticky),
        .any_event(a_any), .count(a_count)
    );

    edge_event_detector #(
        .WIDTH(8), .SYNC_STAGES(2), .FILTER_CYCLES(3), .CNT_W(8)
    ) u_b (
        .clk(clk), .resetn(resetn), .din(b_din),
        .rise_en(b_rise), .fall_en(b_fall), .clr(b_clr),
        .count_clr(b_cclr), .dout(b_dout), .sticky(b_sticky),
        .any_event(b_any), .count(b_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] act(bit d, int f);
        logic [7:0] r;
        r = 8'h00;
        if (!d) begin
            case (f)
                DOUT:    r = a_dout;
                STK:     r = a_sticky;
                CNT:     r = {4'h0, a_count};
                default: r = {7'h00, a_any};
            endcase
        end else begin
            case (f)
                DOUT:    r = b_dout;
                STK:     r = b_sticky;
                CNT:     r = b_count;
                default: r = {7'h00, b_any};
            endcase
        end
        return r;
    endfunction

    task automatic ex(int c, bit d, int f, logic [7:0] v, string n);
        exp_t e;
        e.cyc = c; e.ph = 1'b0; e.dut = d;
        e.fld = f; e.val = v; e.name = n;
        sb.push_back(e);
    endtask

    task automatic ex_now(bit d, int f, logic [7:0] v, string n);
        exp_t e;
        e.cyc = cyc; e.ph = 1'b1; e.dut = d;
        e.fld = f; e.val = v; e.name = n;
        sb.push_back(e);
    endtask

    task automatic scan(bit ph);
        logic [7:0] got;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc && sb[i].ph == ph) begin
                got = act(sb[i].dut, sb[i].fld);
                checks++;
                if (got !== sb[i].val) begin
                    failures++;
                    $display("FAIL %s (cycle %0d): got %02h expected %02h",
                             sb[i].name, cyc, got, sb[i].val);
                end
                sb.delete(i);
            end
        end
    endtask

    initial forever begin
        @(negedge clk);
        scan(1'b0);
    end

    initial forever begin
        @(async_ev);
        scan(1'b1);
    end

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int c;
        resetn = 1'b0;
        a_din = '0; a_rise = '0; a_fall = '0; a_clr = '0; a_cclr = 1'b0;
        b_din = '0; b_rise = '0; b_fall = '0; b_clr = '0; b_cclr = 1'b0;

        tick(2);
        c = cyc;
        ex(c, 0, DOUT, 8'h00, "a_rst_dout");
        ex(c, 0, STK,  8'h00, "a_rst_sticky");
        ex(c, 0, CNT,  8'h00, "a_rst_count");
        ex(c, 1, DOUT, 8'h00, "b_rst_dout");
        ex(c, 1, STK,  8'h00, "b_rst_sticky");
        ex(c, 1, CNT,  8'h00, "b_rst_count");
        tick(1);
        resetn = 1'b1;
        tick(2);

        // Filtered channel: short glitches must vanish.
        b_rise = 8'h08; b_fall = 8'h08;
        c = cyc;
        b_din = 8'h08;
        ex(c + 3, 1, DOUT, 8'h00, "b_glitch1_a");
        ex(c + 6, 1, DOUT, 8'h00, "b_glitch1_b");
        tick(1);
        b_din = 8'h00;
        tick(8);
        c = cyc;
        b_din = 8'h08;
        ex(c + 5, 1, DOUT, 8'h00, "b_glitch3_a");
        ex(c + 6, 1, DOUT, 8'h00, "b_glitch3_b");
        ex(c + 8, 1, CNT,  8'h00, "b_glitch_count");
        tick(3);
        b_din = 8'h00;
        tick(8);
        c = cyc;
        b_din = 8'h08;
        ex(c + 5, 1, DOUT, 8'h00, "b_rise_early");
        ex(c + 6, 1, DOUT, 8'h08, "b_rise_pulse");
        ex(c + 6, 1, ANY,  8'h01, "b_rise_any");
        ex(c + 7, 1, DOUT, 8'h00, "b_rise_after");
        ex(c + 7, 1, STK,  8'h08, "b_rise_sticky");
        tick(10);
        c = cyc;
        b_din = 8'h00;
        ex(c + 5, 1, DOUT, 8'h00, "b_fall_early");
        ex(c + 6, 1, DOUT, 8'h08, "b_fall_pulse");
        ex(c + 7, 1, DOUT, 8'h00, "b_fall_after");
        ex(c + 8, 1, CNT,  8'h02, "b_fall_count");
        tick(10);

        // Unfiltered rise-only channel 0.
        c = cyc;
        a_rise = 8'h01;
        a_din = 8'h01;
        ex(c + 1, 0, DOUT, 8'h01, "a_rise_pulse");
        ex(c + 1, 0, ANY,  8'h01, "a_rise_any");
        ex(c + 1, 0, STK,  8'h01, "a_rise_sticky");
        ex(c + 2, 0, DOUT, 8'h00, "a_rise_single");
        ex(c + 2, 0, CNT,  8'h01, "a_rise_count");
        ex(c + 4, 0, DOUT, 8'h00, "a_nofall_pulse");
        ex(c + 6, 0, CNT,  8'h01, "a_nofall_count");
        ex(c + 6, 0, STK,  8'h01, "a_sticky_hold");
        tick(3);
        a_din = 8'h00;
        tick(4);

        // Channel 1 toggles with enables off, then rise enabled while high.
        c = cyc;
        a_din = 8'h02;
        ex(c + 1, 0, DOUT, 8'h00, "a_gate_1");
        ex(c + 2, 0, DOUT, 8'h00, "a_gate_2");
        ex(c + 3, 0, DOUT, 8'h00, "a_gate_3");
        ex(c + 4, 0, DOUT, 8'h00, "a_gate_en_high");
        ex(c + 5, 0, DOUT, 8'h00, "a_gate_en_high2");
        ex(c + 7, 0, DOUT, 8'h02, "a_gate_next_rise");
        ex(c + 7, 0, STK,  8'h03, "a_gate_sticky");
        ex(c + 8, 0, CNT,  8'h02, "a_gate_count");
        tick(1);
        a_din = 8'h00;
        tick(1);
        a_din = 8'h02;
        tick(1);
        a_rise = 8'h03;
        tick(2);
        a_din = 8'h00;
        tick(1);
        a_din = 8'h02;
        tick(2);
        a_din = 8'h00;
        a_rise = 8'h00;
        tick(2);

        // Set beats clear on ch2; count_clr keeps the three pulses.
        c = cyc;
        a_rise = 8'h07;
        a_din = 8'h07;
        a_clr = 8'h04;
        ex(c + 1, 0, DOUT, 8'h07, "a_sim_dout");
        ex(c + 1, 0, STK,  8'h07, "a_sim_sticky");
        ex(c + 1, 0, CNT,  8'h02, "a_sim_count_pre");
        ex(c + 2, 0, CNT,  8'h03, "a_cclr_count");
        ex(c + 3, 0, STK,  8'h06, "a_clr_sticky");
        ex(c + 3, 0, CNT,  8'h03, "a_cclr_hold");
        tick(1);
        a_clr = 8'h00;
        a_cclr = 1'b1;
        tick(1);
        a_cclr = 1'b0;
        a_clr = 8'h01;
        tick(1);
        a_clr = 8'h00;

        // Asynchronous reset while a pulse is live and count is 5.
        c = cyc;
        a_rise = 8'hFF;
        a_din = 8'h1F;
        ex(c + 1, 0, DOUT, 8'h18, "a_pre_rst_dout1");
        ex(c + 2, 0, DOUT, 8'h20, "a_pre_rst_dout2");
        ex(c + 2, 0, CNT,  8'h05, "a_pre_rst_count");
        tick(1);
        a_din = 8'h3F;
        tick(1);
        @(negedge clk);
        #1;
        resetn = 1'b0;
        a_din = 8'h01;
        a_rise = 8'h01;
        #1;
        ex_now(0, DOUT, 8'h00, "a_async_dout");
        ex_now(0, STK,  8'h00, "a_async_sticky");
        ex_now(0, CNT,  8'h00, "a_async_count");
        ex_now(0, ANY,  8'h00, "a_async_any");
        -> async_ev;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        c = cyc;
        ex(c,     0, DOUT, 8'h00, "a_rel_dout0");
        ex(c,     0, CNT,  8'h00, "a_rel_count0");
        ex(c + 1, 0, DOUT, 8'h01, "a_rel_pulse");
        ex(c + 2, 0, DOUT, 8'h00, "a_rel_single");
        ex(c + 2, 0, CNT,  8'h01, "a_rel_count");
        tick(2);

        // All channels toggle every cycle, both edges: counter saturates.
        c = cyc;
        a_rise = 8'hFF;
        a_fall = 8'hFF;
        ex(c + 1, 0, DOUT, 8'hFF, "a_tog_first");
        ex(c + 2, 0, CNT,  8'h09, "a_tog_count9");
        ex(c + 3, 0, CNT,  8'h0F, "a_tog_sat");
        ex(c + 4, 0, DOUT, 8'hFF, "a_tog_mid");
        ex(c + 6, 0, DOUT, 8'hFF, "a_tog_last");
        ex(c + 7, 0, DOUT, 8'h00, "a_tog_stop");
        ex(c + 7, 0, CNT,  8'h0F, "a_sat_hold");
        ex(c + 8, 0, CNT,  8'h0F, "a_sat_hold2");
        for (int k = 0; k < 6; k++) begin
            a_din = ~a_din;
            tick(1);
        end
        tick(4);

        foreach (sb[i]) begin
            checks++;
            failures++;
            $display("FAIL %s: never sampled, expected %02h at cycle %0d",
                     sb[i].name, sb[i].val, sb[i].cyc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/edge_event_detector.md
Name: edge_event_detector

Overview:
- Multi-channel, parametrised edge detector.
- Per channel: optional input synchroniser, glitch filter, and rise/fall/both selection; emits a single-cycle registered pulse per accepted edge.
- Also keeps per-channel sticky event flags and a saturating total-event counter.
- Sits between raw asynchronous/status inputs and control logic or interrupt aggregation.

Parameters:
- WIDTH, 8: number of independent channels (>=1).
- SYNC_STAGES, 2: flops in each channel's input synchroniser. 0 = din used directly.
- FILTER_CYCLES, 0: extra consecutive samples a new level must hold before it is accepted. 0 = no filtering.
- CNT_W, 8: width of the total-event counter (>= clog2(WIDTH+1)).

Ports:
- clk  in  1  single clock, rising edge
- resetn  in  1  asynchronous active-low reset
- din  in  WIDTH  raw channel inputs
- rise_en  in  WIDTH  per-channel: pulse on accepted 0->1
- fall_en  in  WIDTH  per-channel: pulse on accepted 1->0
- clr  in  WIDTH  per-channel sticky clear
- count_clr  in  1  clear total-event counter
- dout  out  WIDTH  per-channel single-cycle event pulse, registered
- sticky  out  WIDTH  per-channel latched event flag
- any_event  out  1  OR of dout, combinational from registers
- count  out  CNT_W  saturating total of dout pulses

Behaviour:
- Reset: asynchronous and active-low; all state is cleared immediately while resetn=0.
  - Cleared state: synchroniser flops, filter counters, accepted level q, dout, sticky, count.
  - Outputs read 0 during reset. din is treated as 0 during reset.
  - A din held at 1 through reset release produces one rising edge after the normal latency.
- Synchroniser:
  - s[i] = din[i] after SYNC_STAGES flops, all reset to 0.
  - With SYNC_STAGES=0, s = din.
- Filter, per channel; state is q (accepted level) and fcnt, width clog2(FILTER_CYCLES+1), min 1.
  - If s==q: fcnt<=0.
  - If s!=q and fcnt==FILTER_CYCLES: accept, q<=s, fcnt<=0.
  - If s!=q otherwise: fcnt<=fcnt+1.
  - A glitch shorter than FILTER_CYCLES+1 samples is discarded and no pulse is produced.
- Edge/pulse:
  - On the clock edge that accepts a change, dout[i] <= (s & rise_en[i]) | (~s & fall_en[i]). Otherwise dout[i] <= 0.
  - rise_en and fall_en are sampled at the accepting edge.
  - Both enables = both edges. Neither enable = level still tracked, no pulse.
- Latency:
  - With SYNC_STAGES=0 and FILTER_CYCLES=0, dout is high for the cycle after the first clock edge that samples din=1, with q=0 beforehand.
  - In general, add SYNC_STAGES + FILTER_CYCLES cycles.
- Pulse width:
  - dout is high exactly 1 cycle per accepted edge.
  - Back-to-back edges are possible only when FILTER_CYCLES=0 and din toggles every cycle. This gives pulses on consecutive cycles when both enables are set.
- Sticky:
  - sticky[i] <= 1 when the pulse is being set (same edge as dout[i]<=1).
  - Otherwise sticky[i] <= 0 if clr[i]=1.
  - When set and clear coincide, set wins.
- Counter:
  - Each cycle, count += popcount(dout), saturating at 2^CNT_W-1; it never wraps.
  - count_clr=1 gives count <= popcount(dout) that cycle, so the clear does not lose pulses.
- any_event: |dout; no additional latency.
- Channels are fully independent apart from the shared counter.

Test Plan:
- S=0, F=0, rise_en=1, fall_en=0: din[0] 0->1 sampled at edge k, held high -> dout[0]=1 only in cycle k+1; sticky[0]=1 from k+1; count=1; no pulse on the later 1->0.
- S=2, F=3, both enables on ch3: din[3] 1-cycle and 3-cycle high glitches -> no pulse. Then a 4-cycle-stable high -> one pulse 2+3 cycles after the first-sample edge. Falling 4-cycle-stable low -> second pulse; count=2.
- S=0, F=0, WIDTH=8, both enables: din toggling every cycle on all channels -> dout=8'hFF every cycle. With CNT_W=4, count saturates at 15 and holds.
- Simultaneous events: clr[2] asserted on the same edge ch2 pulses -> sticky[2] stays 1. count_clr with 3 pulses in that cycle -> count=3 next cycle.
- Reset mid-operation: resetn driven low asynchronously between edges while dout=1 and count=5 -> dout, sticky, count read 0 immediately. Release with din=1 -> one rise pulse after the normal latency.
- Mode gating: rise_en=0, fall_en=0 on ch1 with din[1] toggling -> dout[1]=0. Enable rise_en while din[1] is already high -> no pulse until the next 0->1.
